// File: rtl/dice_mon_pkg.sv
// Shared types and constants for the dice result capture monitor.
// Seven-segment patterns are {A,B,C,D,E,F,G}, active-high.
package dice_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        SETTLE,
        CAPTURE
    } state_e;

    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;

    localparam logic [3:0] FACE_INVALID = 4'hF;

endpackage

// File: rtl/seg7_to_face.sv
// Combinational seven-segment to die-face decoder.
// Anything that is not a 1..6 die face decodes to FACE_INVALID.
module seg7_to_face
    import dice_mon_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_face
);

    always_comb begin
        o_face = FACE_INVALID;
        unique case (1'b1)
            (i_seg == SEG_1): o_face = 4'd1;
            (i_seg == SEG_2): o_face = 4'd2;
            (i_seg == SEG_3): o_face = 4'd3;
            (i_seg == SEG_4): o_face = 4'd4;
            (i_seg == SEG_5): o_face = 4'd5;
            (i_seg == SEG_6): o_face = 4'd6;
            default:          o_face = FACE_INVALID;
        endcase
    end

endmodule

// File: rtl/dice_result_capture.sv
// Dice display monitor: waits for settled digits after a roll, then captures.
// Define DICE_BUZZER_CHECK_EN to require a buzzer pulse during SETTLE.
module dice_result_capture
    import dice_mon_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SW,
    input  logic [6:0]       SEG1,
    input  logic [6:0]       SEG2,
    input  logic             Buzzer,
    output logic [3:0]       DIE1,
    output logic [3:0]       DIE2,
    output logic [3:0]       SUM,
    output logic             DOUBLES,
    output logic             RESULT_VALID,
    output logic [CNT_W-1:0] ROLL_COUNT,
    output logic             ERR,
    output logic             BUSY
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_sw_meta;
    logic             r_sw_sync;
    logic [6:0]       r_seg1_q;
    logic [6:0]       r_seg2_q;
    logic [6:0]       r_seg1_qq;
    logic [6:0]       r_seg2_qq;
    logic [STB_W-1:0] r_stable_cnt;
    logic [TO_W-1:0]  r_timeout_cnt;
    logic [3:0]       r_die1;
    logic [3:0]       r_die2;
    logic [3:0]       r_sum;
    logic             r_doubles;
    logic             r_result_valid;
    logic [CNT_W-1:0] r_roll_cnt;
    logic             r_err;
    logic [3:0]       w_face1;
    logic [3:0]       w_face2;
    logic             w_faces_ok;
    logic             w_seg_chg;
    logic             w_stable_hit;
    logic             w_timeout_hit;
    logic             w_bz_ok;

    seg7_to_face u_dec1 (
        .i_seg  (r_seg1_q),
        .o_face (w_face1)
    );

    seg7_to_face u_dec2 (
        .i_seg  (r_seg2_q),
        .o_face (w_face2)
    );

    assign w_faces_ok    = (w_face1 != FACE_INVALID) &&
                           (w_face2 != FACE_INVALID);
    assign w_seg_chg     = (r_seg1_q != r_seg1_qq) ||
                           (r_seg2_q != r_seg2_qq);
    assign w_stable_hit  = !w_seg_chg &&
                           (r_stable_cnt == STB_W'(STABLE_CYCLES - 1));
    assign w_timeout_hit = (r_timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef DICE_BUZZER_CHECK_EN
    logic r_bz_meta;
    logic r_bz_sync;
    logic r_bz_seen;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bz_meta <= 1'b0;
            r_bz_sync <= 1'b0;
            r_bz_seen <= 1'b0;
        end else begin
            r_bz_meta <= Buzzer;
            r_bz_sync <= r_bz_meta;
            if (r_state == ROLL && !r_sw_sync) begin
                r_bz_seen <= 1'b0;
            end else if (r_state == SETTLE && r_bz_sync) begin
                r_bz_seen <= 1'b1;
            end
        end
    end

    assign w_bz_ok = r_bz_seen;
`else
    logic w_unused_buzzer;

    assign w_unused_buzzer = Buzzer;
    assign w_bz_ok         = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A rising SW in SETTLE outranks both capture and timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_sw_sync) w_state_next = ROLL;
            end
            ROLL: begin
                if (!r_sw_sync) w_state_next = SETTLE;
            end
            SETTLE: begin
                if (r_sw_sync) begin
                    w_state_next = ROLL;
                end else if (w_stable_hit) begin
                    w_state_next = CAPTURE;
                end else if (w_timeout_hit) begin
                    w_state_next = IDLE;
                end
            end
            CAPTURE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sw_meta <= 1'b0;
            r_sw_sync <= 1'b0;
            r_seg1_q  <= '0;
            r_seg2_q  <= '0;
            r_seg1_qq <= '0;
            r_seg2_qq <= '0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            r_seg1_q  <= SEG1;
            r_seg2_q  <= SEG2;
            r_seg1_qq <= r_seg1_q;
            r_seg2_qq <= r_seg2_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stable_cnt   <= '0;
            r_timeout_cnt  <= '0;
            r_die1         <= '0;
            r_die2         <= '0;
            r_sum          <= '0;
            r_doubles      <= 1'b0;
            r_result_valid <= 1'b0;
            r_roll_cnt     <= '0;
            r_err          <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ROLL: begin
                    if (!r_sw_sync) begin
                        r_stable_cnt  <= '0;
                        r_timeout_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!r_sw_sync) begin
                        if (w_seg_chg) begin
                            r_stable_cnt <= '0;
                        end else if (r_stable_cnt != STB_W'(STABLE_CYCLES)) begin
                            r_stable_cnt <= r_stable_cnt + 1'b1;
                        end
                        if (r_timeout_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                            r_timeout_cnt <= r_timeout_cnt + 1'b1;
                        end
                        if (!w_stable_hit && w_timeout_hit) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (w_faces_ok) begin
                        r_die1         <= w_face1;
                        r_die2         <= w_face2;
                        r_sum          <= w_face1 + w_face2;
                        r_doubles      <= (w_face1 == w_face2);
                        r_result_valid <= 1'b1;
                        r_roll_cnt     <= r_roll_cnt + CNT_W'(1);
                        r_err          <= !w_bz_ok;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DIE1         = r_die1;
    assign DIE2         = r_die2;
    assign SUM          = r_sum;
    assign DOUBLES      = r_doubles;
    assign RESULT_VALID = r_result_valid;
    assign ROLL_COUNT   = r_roll_cnt;
    assign ERR          = r_err;
    assign BUSY         = (r_state != IDLE);

endmodule

// File: tb/tb_dice_result_capture.sv
// Directed bench for dice_result_capture (buzzer scenario when
// DICE_BUZZER_CHECK_EN is defined).
module tb_dice_result_capture;

    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P8 = 7'b1111111;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SW;
    logic [6:0] SEG1;
    logic [6:0] SEG2;
    logic       Buzzer;
    logic [3:0] DIE1;
    logic [3:0] DIE2;
    logic [3:0] SUM;
    logic       DOUBLES;
    logic       RESULT_VALID;
    logic [7:0] ROLL_COUNT;
    logic       ERR;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    dice_result_capture dut (
        .CLK          (CLK),
        .RST          (RST),
        .SW           (SW),
        .SEG1         (SEG1),
        .SEG2         (SEG2),
        .Buzzer       (Buzzer),
        .DIE1         (DIE1),
        .DIE2         (DIE2),
        .SUM          (SUM),
        .DOUBLES      (DOUBLES),
        .RESULT_VALID (RESULT_VALID),
        .ROLL_COUNT   (ROLL_COUNT),
        .ERR          (ERR),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_roll(input logic [6:0] s1, input logic [6:0] s2,
                              input int n);
        SEG1 = s1;
        SEG2 = s2;
        SW   = 1'b1;
        repeat (n) step();
    endtask

    // Drops SW and watches 20 cycles; latency counted from the SW fall.
    task automatic finish_roll(input bit buzz, output int lat,
                               output int pulses);
        lat    = 0;
        pulses = 0;
        SW     = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            Buzzer = buzz && (i >= 3) && (i <= 6);
            step();
            if (RESULT_VALID === 1'b1) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        Buzzer = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; SW = 1'b0; SEG1 = '0; SEG2 = '0; Buzzer = 1'b0;
        repeat (3) step();
        RST = 1'b0;
        step();
        checks++; if (DIE1 !== 4'd0) begin errors++; $display("FAIL reset_die1: got %0d want 0", DIE1); end
        checks++; if (DIE2 !== 4'd0) begin errors++; $display("FAIL reset_die2: got %0d want 0", DIE2); end
        checks++; if (SUM !== 4'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", SUM); end
        checks++; if (DOUBLES !== 1'b0) begin errors++; $display("FAIL reset_doubles: got %b want 0", DOUBLES); end
        checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", RESULT_VALID); end
        checks++; if (ROLL_COUNT !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ROLL_COUNT); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_basic_roll();
        int lat, p;
        start_roll(P4, P2, 30);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", BUSY); end
        finish_roll(1'b1, lat, p);
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++; if (p != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", p); end
        checks++; if (DIE1 !== 4'd4) begin errors++; $display("FAIL basic_die1: got %0d want 4", DIE1); end
        checks++; if (DIE2 !== 4'd2) begin errors++; $display("FAIL basic_die2: got %0d want 2", DIE2); end
        checks++; if (SUM !== 4'd6) begin errors++; $display("FAIL basic_sum: got %0d want 6", SUM); end
        checks++; if (DOUBLES !== 1'b0) begin errors++; $display("FAIL basic_doubles: got %b want 0", DOUBLES); end
        checks++; if (ROLL_COUNT !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", ROLL_COUNT); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", ERR); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_doubles();
        int lat, p;
        start_roll(P6, P6, 30);
        finish_roll(1'b1, lat, p);
        checks++; if (p != 1) begin errors++; $display("FAIL dbl_pulses: got %0d want 1", p); end
        checks++; if (SUM !== 4'd12) begin errors++; $display("FAIL dbl_sum: got %0d want 12", SUM); end
        checks++; if (DOUBLES !== 1'b1) begin errors++; $display("FAIL dbl_doubles: got %b want 1", DOUBLES); end
        checks++; if (ROLL_COUNT !== 8'd2) begin errors++; $display("FAIL dbl_count: got %0d want 2", ROLL_COUNT); end
    endtask

    task automatic test_settle_abort();
        int lat, p;
        start_roll(P5, P3, 30);
        SW = 1'b0;
        repeat (3) step();
        SW = 1'b1;
        p = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (RESULT_VALID === 1'b1) p++;
        end
        checks++; if (p != 0) begin errors++; $display("FAIL abort_pulses: got %0d want 0", p); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", BUSY); end
        checks++; if (ROLL_COUNT !== 8'd2) begin errors++; $display("FAIL abort_count: got %0d want 2", ROLL_COUNT); end
        finish_roll(1'b1, lat, p);
        checks++; if (lat != 8) begin errors++; $display("FAIL abort_resume_lat: got %0d want 8", lat); end
        checks++; if (SUM !== 4'd8) begin errors++; $display("FAIL abort_resume_sum: got %0d want 8", SUM); end
        checks++; if (ROLL_COUNT !== 8'd3) begin errors++; $display("FAIL abort_resume_count: got %0d want 3", ROLL_COUNT); end
    endtask

    task automatic test_invalid_face();
        int lat, p;
        start_roll(P3, P8, 30);
        finish_roll(1'b1, lat, p);
        checks++; if (p != 0) begin errors++; $display("FAIL inv_pulses: got %0d want 0", p); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL inv_err: got %b want 1", ERR); end
        checks++; if (DIE1 !== 4'd5) begin errors++; $display("FAIL inv_die1_hold: got %0d want 5", DIE1); end
        checks++; if (SUM !== 4'd8) begin errors++; $display("FAIL inv_sum_hold: got %0d want 8", SUM); end
        checks++; if (ROLL_COUNT !== 8'd3) begin errors++; $display("FAIL inv_count: got %0d want 3", ROLL_COUNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL inv_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_error_clear();
        int lat, p;
        start_roll(P3, P5, 30);
        finish_roll(1'b1, lat, p);
        checks++; if (p != 1) begin errors++; $display("FAIL clr_pulses: got %0d want 1", p); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL clr_err: got %b want 0", ERR); end
        checks++; if (DIE1 !== 4'd3) begin errors++; $display("FAIL clr_die1: got %0d want 3", DIE1); end
        checks++; if (DIE2 !== 4'd5) begin errors++; $display("FAIL clr_die2: got %0d want 5", DIE2); end
        checks++; if (SUM !== 4'd8) begin errors++; $display("FAIL clr_sum: got %0d want 8", SUM); end
        checks++; if (ROLL_COUNT !== 8'd4) begin errors++; $display("FAIL clr_count: got %0d want 4", ROLL_COUNT); end
    endtask

    // Toggling SEG1 every 2 cycles keeps the stable counter below 2,
    // so SETTLE must expire 3 + 64 cycles after the SW fall.
    task automatic test_timeout();
        int errlat, p;
        start_roll(P4, P2, 30);
        SW = 1'b0;
        errlat = 0;
        p = 0;
        for (int i = 1; i <= 100; i++) begin
            SEG1   = ((i / 2) % 2 == 1) ? P2 : P4;
            Buzzer = 1'b1;
            step();
            if (RESULT_VALID === 1'b1) p++;
            if (ERR === 1'b1 && errlat == 0) errlat = i;
        end
        Buzzer = 1'b0;
        checks++; if (errlat != 67) begin errors++; $display("FAIL to_err_cycle: got %0d want 67", errlat); end
        checks++; if (p != 0) begin errors++; $display("FAIL to_pulses: got %0d want 0", p); end
        checks++; if (DIE1 !== 4'd3) begin errors++; $display("FAIL to_die1_hold: got %0d want 3", DIE1); end
        checks++; if (SUM !== 4'd8) begin errors++; $display("FAIL to_sum_hold: got %0d want 8", SUM); end
        checks++; if (ROLL_COUNT !== 8'd4) begin errors++; $display("FAIL to_count: got %0d want 4", ROLL_COUNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_reset_mid_settle();
        int p;
        start_roll(P6, P6, 10);
        SW = 1'b0;
        repeat (5) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++; if (DIE1 !== 4'd0) begin errors++; $display("FAIL rst_mid_die1: got %0d want 0", DIE1); end
        checks++; if (SUM !== 4'd0) begin errors++; $display("FAIL rst_mid_sum: got %0d want 0", SUM); end
        checks++; if (ROLL_COUNT !== 8'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", ROLL_COUNT); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", ERR); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", BUSY); end
        p = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (RESULT_VALID === 1'b1) p++;
        end
        checks++; if (p != 0) begin errors++; $display("FAIL rst_mid_pulses: got %0d want 0", p); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_stay_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_snake_eyes();
        int lat, p;
`ifdef DICE_BUZZER_CHECK_EN
        start_roll(P1, P1, 30);
        finish_roll(1'b0, lat, p);
        checks++; if (p != 1) begin errors++; $display("FAIL bz_off_pulses: got %0d want 1", p); end
        checks++; if (SUM !== 4'd2) begin errors++; $display("FAIL bz_off_sum: got %0d want 2", SUM); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL bz_off_err: got %b want 1", ERR); end
        checks++; if (ROLL_COUNT !== 8'd1) begin errors++; $display("FAIL bz_off_count: got %0d want 1", ROLL_COUNT); end
        start_roll(P1, P1, 30);
        finish_roll(1'b1, lat, p);
        checks++; if (p != 1) begin errors++; $display("FAIL bz_on_pulses: got %0d want 1", p); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL bz_on_err: got %b want 0", ERR); end
        checks++; if (ROLL_COUNT !== 8'd2) begin errors++; $display("FAIL bz_on_count: got %0d want 2", ROLL_COUNT); end
`else
        start_roll(P1, P1, 30);
        finish_roll(1'b0, lat, p);
        checks++; if (p != 1) begin errors++; $display("FAIL ones_pulses: got %0d want 1", p); end
        checks++; if (lat != 8) begin errors++; $display("FAIL ones_latency: got %0d want 8", lat); end
        checks++; if (SUM !== 4'd2) begin errors++; $display("FAIL ones_sum: got %0d want 2", SUM); end
        checks++; if (DOUBLES !== 1'b1) begin errors++; $display("FAIL ones_doubles: got %b want 1", DOUBLES); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL ones_err: got %b want 0", ERR); end
        checks++; if (ROLL_COUNT !== 8'd1) begin errors++; $display("FAIL ones_count: got %0d want 1", ROLL_COUNT); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_roll();
        test_doubles();
        test_settle_abort();
        test_invalid_face();
        test_error_clear();
        test_timeout();
        test_reset_mid_settle();
        test_snake_eyes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dice_result_capture.md
Name: dice_result_capture

Overview:
- Reader side of the dice display interface. It watches the two 7-segment digit buses, the roll switch and the buzzer.
- It decodes the segment patterns back to numbers and waits for the display to settle after the roll stops.
- It then captures the two dice faces as a validated result with sum, doubles flag and roll count.
- It sits beside the dice block on the board as a self-check and scoring monitor.

Parameters:
- STABLE_CYCLES, 4, consecutive CLK cycles with unchanged segment inputs required before capture.
- TIMEOUT_CYCLES, 64, maximum cycles spent in SETTLE before the capture is abandoned with an error.
- CNT_W, 8, width of the roll counter.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- SW  in  1  roll switch (1 = rolling); asynchronous to CLK.
- SEG1  in  7  digit 1 segments {A1,B1,C1,D1,E1,F1,G1}, active-high.
- SEG2  in  7  digit 2 segments {A2..G2}, same ordering.
- Buzzer  in  1  buzzer output of the dice block.
- DIE1  out  4  captured face, digit 1.
- DIE2  out  4  captured face, digit 2.
- SUM  out  4  DIE1+DIE2, range 2..12.
- DOUBLES  out  1  DIE1==DIE2 at capture.
- RESULT_VALID  out  1  one-cycle pulse when a new result is captured.
- ROLL_COUNT  out  CNT_W  number of successful captures.
- ERR  out  1  sticky error; cleared by RST or by the next successful capture.
- BUSY  out  1  high when state is not IDLE.

Behaviour:
- Input conditioning
  - SW passes through a 2-flop synchronizer.
  - SEG1 and SEG2 are registered once (seg_q) and compared with the previous sample (seg_qq) to detect change.
- Decode
  - 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6.
  - Any other pattern, including 0, 7, 8, 9 and blank, is an invalid face (code 4'hF).
- FSM states
  - IDLE: on synced SW=1 go to ROLL.
  - ROLL: stay while SW=1. On SW=0, clear the stable and timeout counters and go to SETTLE.
  - SETTLE:
    - SW=1 returns to ROLL with no capture. This takes priority over everything else in the cycle.
    - Any segment change resets the stable counter. Otherwise the stable counter increments, saturating.
    - The timeout counter increments every cycle.
    - When stable count reaches STABLE_CYCLES, go to CAPTURE.
    - If the timeout reaches TIMEOUT_CYCLES first, set ERR and go to IDLE. Outputs are unchanged.
  - CAPTURE (one cycle):
    - If both faces are valid: register DIE1, DIE2, SUM, DOUBLES; pulse RESULT_VALID; increment ROLL_COUNT, wrapping at 2^CNT_W; clear ERR.
    - If either face is invalid: set ERR; no pulse; DIE/SUM/DOUBLES hold; count unchanged.
    - Then go to IDLE.
- Latency
  - RESULT_VALID rises 2 (sync) + 1 (seg reg) + STABLE_CYCLES + 1 cycles after the SW falling edge when segments are already static. That is 8 cycles at the default STABLE_CYCLES.
- Reset values
  - State IDLE; DIE1, DIE2, SUM = 0; DOUBLES, RESULT_VALID, ERR, BUSY = 0; ROLL_COUNT = 0; all counters 0.
  - RST mid-roll or mid-settle aborts immediately with no partial capture.
- SUM is computed 4 bits wide with no overflow, since the maximum is 12.

Optional Feature:
- Macro: DICE_BUZZER_CHECK_EN.
- When defined:
  - Buzzer (2-flop synced) must have been seen high at least once between entering SETTLE and CAPTURE.
  - Otherwise CAPTURE still records the result but sets ERR together with the RESULT_VALID pulse.
- When undefined, the Buzzer input is ignored and no synchronizer is instantiated for it.

Decomposition:
- Package dice_mon_pkg:
  - State enum {IDLE, ROLL, SETTLE, CAPTURE}.
  - Seven-segment pattern constants SEG_1..SEG_6.
  - Invalid-face code 4'hF.
- Sub-module seg7_to_face: combinational pattern-to-face decoder, instantiated twice.

Test Plan:
- Reset, then SW=1 for 30 cycles, then SW=0 with SEG1=0110011 (4) and SEG2=1101101 (2) static -> RESULT_VALID pulse at 8 cycles; DIE1=4, DIE2=2, SUM=6, DOUBLES=0, ROLL_COUNT=1.
- Second roll ending with SEG1=SEG2=1011111 (6) -> SUM=12, DOUBLES=1, ROLL_COUNT=2.
- SW returns high 2 cycles into SETTLE -> state ROLL, no RESULT_VALID, ROLL_COUNT unchanged.
- SW=0 with SEG1 toggling every 2 cycles -> no capture, ERR=1 after 64 SETTLE cycles, outputs hold.
- SW=0 with SEG2=1111111 (8) static -> ERR=1, no pulse. Next valid roll (3,5) -> ERR clears, SUM=8.
- With DICE_BUZZER_CHECK_EN defined and Buzzer held 0, roll ending (1,1) -> RESULT_VALID=1, SUM=2, ERR=1. With Buzzer pulsed during SETTLE -> ERR=0.
